// File: rtl/core_pkg.sv
// Shared types for the RV32 core pipeline: decoded control bundle and ALU operations.
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef struct packed {
    logic    regWrite;
    logic    memRead;
    logic    memWrite;
    logic    memToReg;
    logic    aluSrc;
    alu_op_t aluOp;
    logic    branch;
    logic    jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the instruction in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              i_valid_ex,
  input  logic              i_mem_read_ex,
  input  logic [REG_AW-1:0] i_rd_ex,
  input  logic              i_valid_id,
  input  logic [REG_AW-1:0] i_rs1_id,
  input  logic [REG_AW-1:0] i_rs2_id,
  input  logic              i_use_rs1_id,
  input  logic              i_use_rs2_id,
  output logic              o_load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit  = i_use_rs1_id && (i_rd_ex == i_rs1_id);
  assign w_rs2_hit  = i_use_rs2_id && (i_rd_ex == i_rs2_id);
  // x0 is never a real dependency, so a load to x0 cannot stall
  assign o_load_use = i_valid_ex && i_mem_read_ex && (i_rd_ex != '0) && i_valid_id &&
                      (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands, inserts load-use bubbles, honours hold/flush.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_id,
  input  logic [XLEN-1:0]   pc_id,
  input  logic [XLEN-1:0]   rs1_data_id,
  input  logic [XLEN-1:0]   rs2_data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              useRs1_id,
  input  logic              useRs2_id,
  input  ctrl_t             ctrl_id,
  input  logic              hold_ex,
  input  logic              flush_ex,
  output logic              valid_ex,
  output logic [XLEN-1:0]   pc_ex,
  output logic [XLEN-1:0]   rs1_data_ex,
  output logic [XLEN-1:0]   rs2_data_ex,
  output logic [XLEN-1:0]   imm_ex,
  output logic [REG_AW-1:0] rs1_ex,
  output logic [REG_AW-1:0] rs2_ex,
  output logic [REG_AW-1:0] rd_ex,
  output ctrl_t             ctrl_ex,
  output logic              stall_id,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_AW-1:0] r_rs1;
  logic [REG_AW-1:0] r_rs2;
  logic [REG_AW-1:0] r_rd;
  ctrl_t             r_ctrl;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic              w_load_use;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .i_valid_ex    (r_valid),
    .i_mem_read_ex (r_ctrl.memRead),
    .i_rd_ex       (r_rd),
    .i_valid_id    (valid_id),
    .i_rs1_id      (rs1_id),
    .i_rs2_id      (rs2_id),
    .i_use_rs1_id  (useRs1_id),
    .i_use_rs2_id  (useRs2_id),
    .o_load_use    (w_load_use)
  );

  // A flush overrides the hazard: the dependent instruction is being killed anyway
  assign stall_id = !rst && (hold_ex || (w_load_use && !flush_ex));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_ctrl       <= CTRL_NOP;
      r_bubble_cnt <= '0;
    end else if (hold_ex) begin
      r_valid <= r_valid;
    end else if (flush_ex || w_load_use) begin
      // Bubble: zeroed register indices keep the forwarding unit from matching it
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_NOP;
      if (!flush_ex) begin
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
      end
    end else begin
      r_valid    <= valid_id;
      r_pc       <= pc_id;
      r_rs1_data <= rs1_data_id;
      r_rs2_data <= rs2_data_id;
      r_imm      <= imm_id;
      r_rs1      <= rs1_id;
      r_rs2      <= rs2_id;
      r_rd       <= rd_id;
      r_ctrl     <= valid_id ? ctrl_id : CTRL_NOP;
    end
  end

  assign valid_ex     = r_valid;
  assign pc_ex        = r_pc;
  assign rs1_data_ex  = r_rs1_data;
  assign rs2_data_ex  = r_rs2_data;
  assign imm_ex       = r_imm;
  assign rs1_ex       = r_rs1;
  assign rs2_ex       = r_rs2;
  assign rd_ex        = r_rd;
  assign ctrl_ex      = r_ctrl;
  assign bubble_count = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit counter instance plus a 2-bit one sharing stimulus.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        valid_id;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        useRs1_id, useRs2_id;
  ctrl_t       ctrl_id;
  logic        hold_ex, flush_ex;

  logic        valid_ex, stall_id;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  ctrl_t       ctrl_ex;
  logic [15:0] bubble_count;

  logic        s_valid_ex, s_stall_id;
  logic [31:0] s_pc_ex, s_rs1_data_ex, s_rs2_data_ex, s_imm_ex;
  logic [4:0]  s_rs1_ex, s_rs2_ex, s_rd_ex;
  ctrl_t       s_ctrl_ex;
  logic [1:0]  s_bubble_count;

  int n_chk = 0;
  int n_err = 0;

  ctrl_t c_lw, c_add;

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .useRs1_id(useRs1_id), .useRs2_id(useRs2_id), .ctrl_id(ctrl_id),
    .hold_ex(hold_ex), .flush_ex(flush_ex),
    .valid_ex(valid_ex), .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex), .rs1_ex(rs1_ex),
    .rs2_ex(rs2_ex), .rd_ex(rd_ex), .ctrl_ex(ctrl_ex),
    .stall_id(stall_id), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .REG_AW(5), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .valid_id(valid_id), .pc_id(pc_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .useRs1_id(useRs1_id), .useRs2_id(useRs2_id), .ctrl_id(ctrl_id),
    .hold_ex(hold_ex), .flush_ex(flush_ex),
    .valid_ex(s_valid_ex), .pc_ex(s_pc_ex), .rs1_data_ex(s_rs1_data_ex),
    .rs2_data_ex(s_rs2_data_ex), .imm_ex(s_imm_ex), .rs1_ex(s_rs1_ex),
    .rs2_ex(s_rs2_ex), .rd_ex(s_rd_ex), .ctrl_ex(s_ctrl_ex),
    .stall_id(s_stall_id), .bubble_count(s_bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input ctrl_t c);
    valid_id    = v;
    pc_id       = pc;
    rs1_data_id = pc ^ 32'h1111_0000;
    rs2_data_id = pc ^ 32'h0000_2222;
    imm_id      = pc + 32'd4;
    rd_id       = rd;
    rs1_id      = rs1;
    rs2_id      = rs2;
    useRs1_id   = u1;
    useRs2_id   = u2;
    ctrl_id     = c;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, 64'(valid_ex), 64'd0);
    chk({tag, ".ctrl"},  64'(ctrl_ex), 64'd0);
    chk({tag, ".rd"},    64'(rd_ex), 64'd0);
    chk({tag, ".rs1"},   64'(rs1_ex), 64'd0);
    chk({tag, ".pc"},    64'(pc_ex), 64'd0);
  endtask

  initial begin
    c_lw  = CTRL_NOP;
    c_lw.regWrite = 1'b1; c_lw.memRead = 1'b1; c_lw.memToReg = 1'b1;
    c_lw.aluSrc = 1'b1;   c_lw.aluOp = ALU_ADD;
    c_add = CTRL_NOP;
    c_add.regWrite = 1'b1; c_add.aluOp = ALU_ADD;

    rst = 1'b1; hold_ex = 1'b0; flush_ex = 1'b0;
    set_id(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_NOP);
    #3;
    chk("rst.valid", 64'(valid_ex), 64'd0);
    chk("rst.stall", 64'(stall_id), 64'd0);
    chk("rst.cnt",   64'(bubble_count), 64'd0);
    #5 rst = 1'b0;

    // capture lw x5, then async reset mid-cycle
    set_id(1'b1, 32'h100, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, c_lw);
    step();
    chk("cap.valid", 64'(valid_ex), 64'd1);
    chk("cap.pc",    64'(pc_ex), 64'h100);
    chk("cap.rs1d",  64'(rs1_data_ex), 64'h1111_0100);
    chk("cap.rs2d",  64'(rs2_data_ex), 64'h0000_2322);
    chk("cap.imm",   64'(imm_ex), 64'h104);
    chk("cap.rd",    64'(rd_ex), 64'd5);
    chk("cap.ctrl",  64'(ctrl_ex), 64'(c_lw));
    hold_ex = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", 64'(valid_ex), 64'd0);
    chk("arst.rd",    64'(rd_ex), 64'd0);
    chk("arst.pc",    64'(pc_ex), 64'd0);
    chk("arst.ctrl",  64'(ctrl_ex), 64'd0);
    chk("arst.stall", 64'(stall_id), 64'd0);
    #1 rst = 1'b0; hold_ex = 1'b0;

    // load-use: lw x5 then add x6,x5,x1
    step();
    chk("lu.lw_in_ex", 64'(rd_ex), 64'd5);
    set_id(1'b1, 32'h104, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, c_add);
    #1;
    chk("lu.stall", 64'(stall_id), 64'd1);
    step();
    chk_bubble("lu.bub");
    chk("lu.cnt",    64'(bubble_count), 64'd1);
    chk("lu.stall2", 64'(stall_id), 64'd0);
    step();
    chk("lu.rs1", 64'(rs1_ex), 64'd5);
    chk("lu.rd",  64'(rd_ex), 64'd6);
    chk("lu.valid", 64'(valid_ex), 64'd1);

    // lw x0 never stalls
    set_id(1'b1, 32'h200, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0, c_lw);
    step();
    set_id(1'b1, 32'h204, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, c_add);
    #1;
    chk("x0.stall", 64'(stall_id), 64'd0);
    step();
    chk("x0.valid", 64'(valid_ex), 64'd1);
    chk("x0.rd",    64'(rd_ex), 64'd6);
    chk("x0.ctrl",  64'(ctrl_ex), 64'(c_add));
    chk("x0.cnt",   64'(bubble_count), 64'd1);

    // non-valid ID capture zeroes control
    set_id(1'b0, 32'h300, 5'd7, 5'd1, 5'd1, 1'b1, 1'b1, c_add);
    step();
    chk("nv.valid", 64'(valid_ex), 64'd0);
    chk("nv.ctrl",  64'(ctrl_ex), 64'd0);

    // load-use with flush: no stall, bubble, count unchanged
    set_id(1'b1, 32'h400, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, c_lw);
    step();
    set_id(1'b1, 32'h404, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, c_add);
    flush_ex = 1'b1;
    #1;
    chk("fl.stall", 64'(stall_id), 64'd0);
    step();
    chk_bubble("fl.bub");
    chk("fl.cnt", 64'(bubble_count), 64'd1);
    flush_ex = 1'b0;

    // hold with load-use and flush pending
    set_id(1'b1, 32'h500, 5'd5, 5'd2, 5'd0, 1'b1, 1'b0, c_lw);
    step();
    set_id(1'b1, 32'h504, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1, c_add);
    hold_ex = 1'b1; flush_ex = 1'b1;
    #1;
    chk("hd.stall0", 64'(stall_id), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hd.valid", 64'(valid_ex), 64'd1);
      chk("hd.pc",    64'(pc_ex), 64'h500);
      chk("hd.rd",    64'(rd_ex), 64'd5);
      chk("hd.ctrl",  64'(ctrl_ex), 64'(c_lw));
      chk("hd.cnt",   64'(bubble_count), 64'd1);
      chk("hd.stall", 64'(stall_id), 64'd1);
    end
    hold_ex = 1'b0;
    #1;
    chk("hd.stall_rel", 64'(stall_id), 64'd0);
    step();
    chk_bubble("hd.flush");
    chk("hd.cnt_after", 64'(bubble_count), 64'd1);
    flush_ex = 1'b0;

    // saturation: fresh reset, five load-use bubbles
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    chk("sat.cnt0", 64'(s_bubble_count), 64'd0);
    for (int i = 1; i <= 5; i++) begin
      set_id(1'b1, 32'h600 + 32'(i * 16), 5'd9, 5'd3, 5'd0, 1'b1, 1'b0, c_lw);
      step();
      set_id(1'b1, 32'h604 + 32'(i * 16), 5'd10, 5'd4, 5'd9, 1'b1, 1'b1, c_add);
      #1;
      chk("sat.stall", 64'(s_stall_id), 64'd1);
      step();
      chk("sat.cnt2",  64'(s_bubble_count), 64'((i > 3) ? 3 : i));
      chk("sat.cnt16", 64'(bubble_count), 64'(i));
      chk("sat.valid", 64'(s_valid_ex), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
